// File: rtl/fairy_dsram_responder.sv
// Data-SRAM port responder: serves cache requests from a word-addressed RAM or a
// small MMIO window (LED, COUNT, SCRATCH) with a fixed read latency.
module fairy_dsram_responder #(
    parameter int          ADDR_WIDTH = 14,
    parameter int          READ_LAT   = 1,
    parameter logic [31:0] MMIO_BASE  = 32'h1FAF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_sram_addr_i,
    input  logic [3:0]  data_sram_cen_i,
    input  logic        data_sram_wr_i,
    input  logic [31:0] data_sram_wdata_i,
    output logic [31:0] data_sram_rdata_o,
    output logic        rvalid_o,
    output logic        err_o,
    output logic [15:0] led_o
);

    localparam int WORDS = 1 << ADDR_WIDTH;

    generate
        if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
            $error("fairy_dsram_responder: READ_LAT must be in 1..4");
        end
        if (ADDR_WIDTH < 1 || ADDR_WIDTH > 26) begin : g_bad_addr_width
            $error("fairy_dsram_responder: ADDR_WIDTH must be in 1..26");
        end
    endgenerate

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int k = 0; k < 4; k++)
            res[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
        return res;
    endfunction

    logic [31:0]           mem [WORDS];
    logic [31:0]           count;
    logic [31:0]           scratch;
    logic [15:0]           led;
    logic [28:0]           phys;
    logic                  req;
    logic                  is_mmio;
    logic                  is_ram;
    logic [13:0]           mmio_off;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [31:0]           mmio_rdata;
    logic [31:0]           read_data;
    logic                  unused_bits;

    // Kseg bits are stripped by keeping only the 29-bit physical address.
    assign phys        = data_sram_addr_i[28:0];
    assign req         = |data_sram_cen_i;
    assign is_mmio     = (phys[28:16] == MMIO_BASE[28:16]);
    assign is_ram      = !is_mmio && (phys[28:ADDR_WIDTH+2] == '0);
    assign mmio_off    = phys[15:2];
    assign ram_idx     = data_sram_addr_i[ADDR_WIDTH+1:2];
    assign unused_bits = &{1'b0, data_sram_addr_i[31:29], phys[1:0]};

    always_comb begin
        mmio_rdata = '0;
        case (mmio_off)
            14'd0:   mmio_rdata = {16'h0000, led};
            14'd1:   mmio_rdata = count;
            14'd2:   mmio_rdata = scratch;
            default: mmio_rdata = '0;
        endcase
    end

    always_comb begin
        read_data = '0;
        if (is_mmio)
            read_data = mmio_rdata;
        else if (is_ram)
            read_data = mem[ram_idx];
    end

    always_ff @(posedge clk) begin
        if (!reset && req && is_ram && data_sram_wr_i) begin
            for (int k = 0; k < 4; k++)
                if (data_sram_cen_i[k])
                    mem[ram_idx][8*k +: 8] <= data_sram_wdata_i[8*k +: 8];
        end
    end

    // MMIO registers; a COUNT write takes priority over the free-running increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            led     <= '0;
            count   <= '0;
            scratch <= '0;
            err_o   <= 1'b0;
        end else begin
            err_o <= req && !is_mmio && !is_ram;
            count <= count + 32'd1;
            if (req && data_sram_wr_i && is_mmio) begin
                case (mmio_off)
                    14'd0: begin
                        if (data_sram_cen_i[0]) led[7:0]  <= data_sram_wdata_i[7:0];
                        if (data_sram_cen_i[1]) led[15:8] <= data_sram_wdata_i[15:8];
                    end
                    14'd1:   count   <= merge_bytes(count, data_sram_wdata_i, data_sram_cen_i);
                    14'd2:   scratch <= merge_bytes(scratch, data_sram_wdata_i, data_sram_cen_i);
                    default: ;
                endcase
            end
        end
    end

    logic        vld_p   [READ_LAT];
    logic [31:0] rdata_p [READ_LAT];

    // Stage 0 captures the read at the request edge; later stages only advance
    // on a valid entry, so the last stage holds the previous result when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < READ_LAT; k++) begin
                vld_p[k]   <= 1'b0;
                rdata_p[k] <= '0;
            end
        end else begin
            vld_p[0] <= req && !data_sram_wr_i;
            if (req && !data_sram_wr_i)
                rdata_p[0] <= read_data;
            for (int k = 1; k < READ_LAT; k++) begin
                vld_p[k] <= vld_p[k-1];
                if (vld_p[k-1])
                    rdata_p[k] <= rdata_p[k-1];
            end
        end
    end

    assign data_sram_rdata_o = rdata_p[READ_LAT-1];
    assign rvalid_o          = vld_p[READ_LAT-1];
    assign led_o             = led;

endmodule
